// File: rtl/operand_fetch_pkg.sv
// Shared widths, shift codes and fetch FSM states for the operand fetch stage.
package operand_fetch_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD_A = 2'b01,
    LOAD_B = 2'b10,
    VALID  = 2'b11
  } state_t;

endpackage

// File: rtl/operand_fetch_regfile.sv
// NREGS x DATA_W register file: one write port, one combinational read port
// with write-first bypass, synchronously cleared by reset.
module regfile
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [REG_AW-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic [REG_AW-1:0] readnum,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [NREGS];

  // NOTE: this storage is architectural state that must read 0 after reset,
  // so it is cleared explicitly; that keeps it in flops rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (write) begin
      regs[writenum] <= data_in;
    end
  end

  // A same-cycle write to the register being read is forwarded.
  assign rdata = (write && (writenum == readnum)) ? data_in : regs[readnum];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads Rn then Rm through one shared port and presents
// A, B and the shift code to the shifter/ALU with a valid/ready handshake.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [REG_AW-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [1:0]        shift_in,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [1:0]        shift_out
);

  state_t            state, state_nxt;
  logic [REG_AW-1:0] rn_q, rm_q, readnum;
  shift_t            shift_q;
  logic [DATA_W-1:0] rdata;

  regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .writenum (writenum),
    .data_in  (data_in),
    .readnum  (readnum),
    .rdata    (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment first means every path drives state_nxt,
  // so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = LOAD_A;
      LOAD_A:  state_nxt = LOAD_B;
      LOAD_B:  state_nxt = VALID;
      VALID:   if (op_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs come straight from the state register.
  assign req_ready = (state == IDLE);
  assign op_valid  = (state == VALID);
  assign readnum   = (state == LOAD_B) ? rm_q : rn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rn_q      <= '0;
      rm_q      <= '0;
      shift_q   <= SH_NONE;
      a_out     <= '0;
      b_out     <= '0;
      shift_out <= 2'b00;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          rn_q    <= rn;
          rm_q    <= rm;
          shift_q <= shift_t'(shift_in);
        end
        LOAD_A: a_out <= rdata;
        LOAD_B: begin
          b_out     <= rdata;
          shift_out <= shift_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: table-driven fetches with a
// scoreboard of expected operands, plus reset and back-to-back sequences.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset, write, req_valid, req_ready, op_valid, op_ready;
  logic [2:0]  writenum, rn, rm;
  logic [15:0] data_in, a_out, b_out;
  logic [1:0]  shift_in, shift_out;

  operand_fetch dut (
    .clk(clk), .reset(reset), .write(write), .writenum(writenum),
    .data_in(data_in), .req_valid(req_valid), .req_ready(req_ready),
    .rn(rn), .rm(rm), .shift_in(shift_in), .op_valid(op_valid),
    .op_ready(op_ready), .a_out(a_out), .b_out(b_out), .shift_out(shift_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  sh;
  } exp_t;

  typedef struct {
    logic [2:0]  rn, rm;
    logic [1:0]  sh;
    int          stall;   // cycles op_ready is held low in VALID
    int          wr_cyc;  // cycle after acceptance carrying a write (-1: none)
    logic [2:0]  wr_n;
    logic [15:0] wr_d;
    logic [15:0] exp_a, exp_b;
  } vec_t;

  exp_t sb[$];
  int   acc[$];
  vec_t vecs[7];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_a"},  {16'h0, a_out},     {16'h0, e.a});
      check({tag, "_b"},  {16'h0, b_out},     {16'h0, e.b});
      check({tag, "_sh"}, {30'h0, shift_out}, {30'h0, e.sh});
    end
  endtask

  task automatic wr_reg(input logic [2:0] n, input logic [15:0] d);
    write = 1'b1; writenum = n; data_in = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle again.
  task automatic fetch(input string tag, input vec_t v);
    int lat;
    sb.push_back('{v.exp_a, v.exp_b, v.sh});
    check({tag, "_req_ready"}, {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; rn = v.rn; rm = v.rm; shift_in = v.sh; op_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      req_valid = 1'b0;
      write = (lat == v.wr_cyc); writenum = v.wr_n; data_in = v.wr_d;
    end while (!op_valid && lat < 10);
    check({tag, "_latency"}, lat, 3);
    for (int i = 0; i < v.stall; i++) begin
      check({tag, "_stall_valid"}, {31'h0, op_valid}, 32'd1);
      check({tag, "_stall_ready"}, {31'h0, req_ready}, 32'd0);
      check({tag, "_stall_hold"}, {a_out, b_out}, {v.exp_a, v.exp_b});
      @(negedge clk); lat++;
      write = (lat == v.wr_cyc);
    end
    op_ready = 1'b1;
    check({tag, "_valid"}, {31'h0, op_valid}, 32'd1);
    pop_compare(tag);
    @(negedge clk);
    write = 1'b0; op_ready = 1'b0;
    check({tag, "_idle_valid"}, {31'h0, op_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'h0, req_ready}, 32'd1);
  endtask

  initial begin
    vec_t z;
    reset = 1'b1; write = 1'b0; writenum = '0; data_in = '0;
    req_valid = 1'b0; rn = '0; rm = '0; shift_in = '0; op_ready = 1'b0;

    //          rn    rm    sh     stall wr  wr_n  wr_d      exp_a     exp_b
    vecs[0] = '{3'd0, 3'd1, 2'b01, 0,   -1, 3'd0, 16'h0000, 16'h0007, 16'h0002};
    vecs[1] = '{3'd0, 3'd1, 2'b01, 5,    4, 3'd0, 16'h1234, 16'h0007, 16'h0002};
    vecs[2] = '{3'd0, 3'd4, 2'b10, 0,   -1, 3'd0, 16'h0000, 16'h1234, 16'h00F0};
    vecs[3] = '{3'd1, 3'd1, 2'b00, 0,    2, 3'd1, 16'hBEEF, 16'h0002, 16'hBEEF};
    vecs[4] = '{3'd1, 3'd0, 2'b11, 0,    1, 3'd1, 16'h5555, 16'h5555, 16'h1234};
    vecs[5] = '{3'd7, 3'd7, 2'b11, 0,   -1, 3'd0, 16'h0000, 16'h8001, 16'h8001};
    vecs[6] = '{3'd4, 3'd1, 2'b00, 1,    1, 3'd1, 16'h0101, 16'h00F0, 16'h0101};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_a", {16'h0, a_out}, 32'h0);
    check("rst_b", {16'h0, b_out}, 32'h0);
    check("rst_sh", {30'h0, shift_out}, 32'h0);
    check("rst_valid", {31'h0, op_valid}, 32'd0);
    check("rst_ready", {31'h0, req_ready}, 32'd1);
    fetch("zero", '{3'd3, 3'd5, 2'b00, 0, -1, 3'd0, 16'h0, 16'h0000, 16'h0000});

    wr_reg(3'd0, 16'h0007);
    wr_reg(3'd1, 16'h0002);
    wr_reg(3'd4, 16'h00F0);
    wr_reg(3'd7, 16'h8001);
    for (int i = 0; i < 7; i++) fetch($sformatf("vec%0d", i), vecs[i]);

    // Reset during LOAD_B, together with a write that reset must override.
    req_valid = 1'b1; rn = 3'd0; rm = 3'd1; shift_in = 2'b01;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1; write = 1'b1; writenum = 3'd2; data_in = 16'hAAAA;
    @(negedge clk);
    reset = 1'b0; write = 1'b0;
    check("midrst_valid", {31'h0, op_valid}, 32'd0);
    check("midrst_ready", {31'h0, req_ready}, 32'd1);
    check("midrst_ab", {a_out, b_out}, 32'h0);
    check("midrst_sh", {30'h0, shift_out}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_stale", {31'h0, op_valid}, 32'd0);
    end
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      z = '{i[2:0], 3'(7 - i), 2'b00, 0, -1, 3'd0, 16'h0, 16'h0000, 16'h0000};
      fetch($sformatf("clr%0d", i), z);
    end

    // Back-to-back: req_valid held high, downstream always ready.
    wr_reg(3'd7, 16'h8001);
    op_ready = 1'b1; req_valid = 1'b1; rn = 3'd7; rm = 3'd7; shift_in = 2'b11;
    for (int c = 0; c < 8; c++) begin
      if (op_valid) pop_compare("b2b");
      if (req_ready) begin
        acc.push_back(c);
        sb.push_back('{16'h8001, 16'h8001, 2'b11});
      end
      @(negedge clk);
    end
    req_valid = 1'b0; op_ready = 1'b0;
    check("b2b_accepts", acc.size(), 2);
    if (acc.size() == 2) check("b2b_spacing", acc[1] - acc[0], 4);
    check("b2b_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
